// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold for a shared single-owner resource.
// An owner keeps the grant until it releases, drops its request, or MaxHold expires.
module rr_hold_arbiter #(
  parameter  int NumRequests = 4,
  parameter  int MaxHold     = 8,
  localparam int IdW         = $clog2(NumRequests),
  localparam int CntW        = $clog2(MaxHold + 1)
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [NumRequests-1:0] request,
  input  logic                   owner_release,
  output logic [NumRequests-1:0] grant,
  output logic                   grant_valid,
  output logic [IdW-1:0]         grant_id,
  output logic                   timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t                 state;
  logic [IdW-1:0]         ptr;
  logic [CntW-1:0]        hold_cnt;
  logic [NumRequests-1:0] rotated;
  logic [IdW-1:0]         winner;
  logic [IdW:0]           sum;
  logic                   found;
  logic                   ownerDone;
  logic [IdW-1:0]         nextPtr;

  // Rotate requests so bit 0 is the requester at ptr, then take the first set bit.
  always_comb begin
    rotated = NumRequests'({request, request} >> ptr);
    winner  = '0;
    found   = 1'b0;
    sum     = '0;
    for (int i = 0; i < NumRequests; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IdW + 1)'(i);
        if (sum >= (IdW + 1)'(NumRequests)) begin
          sum = sum - (IdW + 1)'(NumRequests);
        end
        winner = sum[IdW-1:0];
      end
    end
  end

  always_comb begin
    ownerDone = owner_release || !request[grant_id];
    nextPtr   = (grant_id == IdW'(NumRequests - 1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant       <= NumRequests'(1) << winner;
            grant_id    <= winner;
            grant_valid <= 1'b1;
            hold_cnt    <= CntW'(1);
            state       <= GRANT;
          end
        end
        GRANT: begin
          // Release/drop outranks the hold limit, so timeout only fires on a forced revoke.
          if (ownerDone || (hold_cnt == CntW'(MaxHold))) begin
            timeout     <= !ownerDone;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= nextPtr;
            hold_cnt    <= '0;
            state       <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
